// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences accesses onto the single-port mem block.
// Each access is IDLE -> SETUP -> STROBE -> DONE, with every mem-side signal registered.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_w,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [DATA_W-1:0]   mem_di,
    input  logic [DATA_W/2-1:0] mem_dou,
    input  logic [DATA_W/2-1:0] mem_dol
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StDone   = 2'd3
    } state_e;

    state_e state;
    logic   owner;  // owner of the current or most recent transaction
    logic   we_r;
    logic   pick1;

    // Port 1 wins if it is the only requester, or on contention when port 0 went last.
    assign pick1 = req1 & (~req0 | ~owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            owner  <= 1'b1;
            we_r   <= 1'b0;
            mem_a  <= '0;
            mem_di <= '0;
            mem_w  <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            rdata  <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            mem_w <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        owner  <= pick1;
                        we_r   <= pick1 ? we1 : we0;
                        mem_a  <= pick1 ? addr1 : addr0;
                        mem_di <= pick1 ? wdata1 : wdata0;
                        gnt0   <= ~pick1;
                        gnt1   <= pick1;
                        state  <= StSetup;
                    end
                end
                StSetup: begin
                    // Address and data settled for a full cycle; strobe next.
                    mem_w <= we_r;
                    state <= StStrobe;
                end
                StStrobe: begin
                    rdata <= {mem_dou, mem_dol};
                    done0 <= ~owner;
                    done1 <= owner;
                    state <= StDone;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64K x 16 memory model.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rdata;
    logic        mem_w;
    logic [15:0] mem_a, mem_di;
    logic [7:0]  mem_dou, mem_dol;

    logic [15:0] mem_arr [0:65535];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0(req0),
        .req1(req1),
        .we0(we0),
        .we1(we1),
        .addr0(addr0),
        .addr1(addr1),
        .wdata0(wdata0),
        .wdata1(wdata1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .done0(done0),
        .done1(done1),
        .rdata(rdata),
        .mem_w(mem_w),
        .mem_a(mem_a),
        .mem_di(mem_di),
        .mem_dou(mem_dou),
        .mem_dol(mem_dol)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write-through while W is high, otherwise read the addressed word.
    assign {mem_dou, mem_dol} = mem_w ? mem_di : mem_arr[mem_a];
    always @(posedge clk) if (mem_w) mem_arr[mem_a] <= mem_di;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // One access from an idle arbiter; returns in the following IDLE cycle.
    task automatic xact(input bit port, input bit we, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input string name);
        if (!port) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        tick();
        checks++;
        if ({gnt1, gnt0} !== (port ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s grant: got gnt1,gnt0=%b required %b", name, {gnt1, gnt0},
                     port ? 2'b10 : 2'b01);
        end
        checks++;
        if (mem_w !== 1'b0 || mem_a !== a) begin
            errors++;
            $display("FAIL %s setup: got mem_w=%b mem_a=%h required 0 %h", name, mem_w, mem_a, a);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        checks++;
        if (mem_w !== we || mem_a !== a || (we && mem_di !== d)) begin
            errors++;
            $display("FAIL %s strobe: got mem_w=%b mem_a=%h mem_di=%h required %b %h %h",
                     name, mem_w, mem_a, mem_di, we, a, d);
        end
        tick();
        checks++;
        if ({done1, done0} !== (port ? 2'b10 : 2'b01) || mem_w !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got done1,done0=%b mem_w=%b required %b 0", name,
                     {done1, done0}, mem_w, port ? 2'b10 : 2'b01);
        end
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", name, rdata, exp);
        end
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_w} !== 5'b0) begin
            errors++;
            $display("FAIL %s idle: got gnt0,gnt1,done0,done1,mem_w=%b required 00000", name,
                     {gnt0, gnt1, done0, done1, mem_w});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_w, gnt0, gnt1, done0, done1} !== 5'b0 || rdata !== 16'h0 ||
            mem_a !== 16'h0 || mem_di !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got ctl=%b rdata=%h mem_a=%h mem_di=%h required all 0",
                     {mem_w, gnt0, gnt1, done0, done1}, rdata, mem_a, mem_di);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        xact(1'b0, 1'b1, 16'h0010, 16'hA55A, 16'hA55A, "single_write");
        // Idle inputs changing must not disturb the held memory-side registers.
        addr0 = 16'hFFFF;
        wdata0 = 16'h0000;
        tick();
        checks++;
        if (mem_a !== 16'h0010 || mem_di !== 16'hA55A) begin
            errors++;
            $display("FAIL idle_hold: got mem_a=%h mem_di=%h required 0010 A55A", mem_a, mem_di);
        end
    endtask

    task automatic test_readback();
        xact(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA55A, "readback");
    endtask

    task automatic test_contention();
        int gap;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0001; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0002; wdata1 = 16'h2222;
        tick();
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL contention_first: got gnt1,gnt0=%b required 01", {gnt1, gnt0});
        end
        req0 = 1'b0;
        gap = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (gnt1 === 1'b1) begin
                gap = i;
                break;
            end
        end
        checks++;
        if (gap !== 4) begin
            errors++;
            $display("FAIL contention_gap: got gnt1 %0d cycles after gnt0 required 4", gap);
        end
        req1 = 1'b0;
        tick();
        tick();
        tick();
        xact(1'b0, 1'b0, 16'h0001, 16'h0000, 16'h1111, "contention_read0");
        xact(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222, "contention_read1");
    endtask

    task automatic test_sustained();
        int n_gnt = 0;
        int both = 0;
        int bad_time = 0;
        logic [3:0] order = 4'b0;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if ((gnt0 & gnt1) || (done0 & done1)) both++;
            if ((gnt0 | gnt1) !== ((i % 4) == 1)) bad_time++;
            if (gnt0 | gnt1) begin
                if (n_gnt < 4) order[n_gnt] = gnt1;
                n_gnt++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (n_gnt !== 4 || order !== 4'b1010) begin
            errors++;
            $display("FAIL sustained_order: got %0d grants order(3..0)=%b required 4 1010",
                     n_gnt, order);
        end
        checks++;
        if (both !== 0 || bad_time !== 0) begin
            errors++;
            $display("FAIL sustained_exclusive: got %0d dual cycles %0d mistimed required 0 0",
                     both, bad_time);
        end
        tick();
    endtask

    task automatic test_late_request();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'h3333;
        tick();
        req0 = 1'b0;
        tick();
        checks++;
        if (mem_w !== 1'b1) begin
            errors++;
            $display("FAIL late_strobe: got mem_w=%b required 1", mem_w);
        end
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0003;
        tick();
        checks++;
        if (done0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL late_done0: got done0=%b gnt1=%b required 1 0", done0, gnt1);
        end
        tick();
        checks++;
        if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL late_idle: got gnt1=%b required 0", gnt1);
        end
        // One IDLE cycle separates done0 from gnt1.
        tick();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL late_gnt1: got gnt1=%b required 1", gnt1);
        end
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if (done1 !== 1'b1 || rdata !== 16'h3333) begin
            errors++;
            $display("FAIL late_done1: got done1=%b rdata=%h required 1 3333", done1, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int wait_n = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'hBEEF;
        tick();
        req0 = 1'b0;
        tick();
        checks++;
        if (mem_w !== 1'b1 || rdata === 16'h0) begin
            errors++;
            $display("FAIL midrst_pre: got mem_w=%b rdata=%h required 1 nonzero", mem_w, rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_w, gnt0, gnt1, done0, done1} !== 5'b0 || rdata !== 16'h0 ||
            mem_a !== 16'h0 || mem_di !== 16'h0) begin
            errors++;
            $display("FAIL midrst_async: got ctl=%b rdata=%h mem_a=%h mem_di=%h required all 0",
                     {mem_w, gnt0, gnt1, done0, done1}, rdata, mem_a, mem_di);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done0 | done1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL midrst_nodone: got %0d done cycles required 0", n_done);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        tick();
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_first: got gnt1,gnt0=%b required 01", {gnt1, gnt0});
        end
        req0 = 1'b0;
        while (gnt1 !== 1'b1 && wait_n < 8) begin
            tick();
            wait_n++;
        end
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_second: got no gnt1 within 8 cycles required gnt1");
        end
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0;
        test_reset();
        test_single_write();
        test_readback();
        test_contention();
        test_sustained();
        test_late_request();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
